i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C responder (target) for the codec control bus; the other end of the team's I2C controller.
- Used in simulation and on FPGA as a stand-in for the ADAU1761 control port. It also serves as a loopback target for controller bring-up.
- Decodes START/STOP, matches the 7-bit chip address, receives a 16-bit register address MSB-first, then writes or reads byte-wide registers with auto-increment.
- The register store sits outside this block and is reached through a simple strobe interface.

Parameters:
- C_CHIP_ADDRESS, 7'h38, 7-bit target address to acknowledge.
- C_AUTO_INC, 1'b1, 1 = register pointer increments after every data byte; 0 = pointer holds.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- scl  input  1  I2C clock from controller (asynchronous to clk).
- sda  inout  1  I2C data, open-drain. Drive 1'b0 when pulling low, else 1'bz.
- reg_addr  output  16  current register pointer.
- reg_wdata  output  8  received write byte, valid while reg_we is high.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read request for reg_addr.
- reg_rdata  input  8  read data, sampled exactly 1 cycle after reg_re.
- busy  output  1  high from address match until STOP, START-mismatch or reset.

Behaviour:
- **Reset** (rst=1 at posedge clk):
  - state=S_IDLE; sda released (z).
  - reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0.
  - Reset mid-transfer aborts immediately: sda is released on the next cycle and no strobe is issued.
- **Input conditioning:**
  - scl and sda are each passed through a 2-flop synchronizer plus a 1-flop history register.
  - Edges are detected on the synchronized values.
  - Pin-to-detection latency is 3 clk.
- **Bus conditions:**
  - START = sda falling while scl high.
  - STOP = sda rising while scl high.
- **Bit timing:**
  - Receive bits are sampled on the detected scl rising edge.
  - Transmit bits and ACK drive change 1 cycle after the detected scl falling edge.
  - Requirement: scl high and low phases are each ≥ 6 clk.
- **Bit counter:** 3 bits, reset to 7 at each byte start. Bytes are MSB first.
- **States:**
  - S_IDLE → S_RX_CHIP_ADDRESS on START.
  - S_RX_CHIP_ADDRESS: shift 8 bits, then latch rnw = bit 0.
    - Address match → S_TX_CHIP_ADDRESS_ACK, busy=1.
    - Mismatch → S_IDLE; sda is never driven.
  - S_TX_CHIP_ADDRESS_ACK → S_RX_ADDRESS.
  - S_RX_ADDRESS → S_TX_ADDRESS_ACK: load reg_addr[15:8].
  - S_TX_ADDRESS_ACK → S_RX_SUB_ADDRESS.
  - S_RX_SUB_ADDRESS → S_TX_SUB_ADDRESS_ACK: load reg_addr[7:0].
    - If rnw=1, pulse reg_re on the scl rising edge of this ACK bit.
  - S_TX_SUB_ADDRESS_ACK → S_RX_WDATA (rnw=0) or S_TX_RDATA (rnw=1).
  - S_RX_WDATA:
    - After the 8th bit, pulse reg_we for 1 cycle with reg_wdata = byte and reg_addr = pointer.
    - Then → S_TX_WDATA_ACK.
  - S_TX_WDATA_ACK:
    - After the ACK falling edge, increment the pointer (if C_AUTO_INC).
    - → S_RX_WDATA.
  - S_TX_RDATA:
    - Shift out the byte captured from reg_rdata.
    - sda is released for 1 bits and driven 0 for 0 bits.
    - → S_RX_RDATA_ACK.
  - S_RX_RDATA_ACK: sample sda on scl rising.
    - ACK (0): increment the pointer, pulse reg_re in the same cycle, → S_TX_RDATA.
    - NACK (1): release sda, → S_IDLE.
- **ACK states:** sda is driven low from the falling edge after bit 0 until the next falling edge.
- **Address pointer:** wraps 16'hFFFF → 16'h0000.
- **Bus events in any state:**
  - STOP → S_IDLE, release sda, busy=0.
  - Repeated START → S_RX_CHIP_ADDRESS, bit counter reset, pointer retained, busy=0 until the next match.
- **Simultaneous events:**
  - START/STOP detection takes priority over the scl edge logic in the same cycle.
  - rst takes priority over everything.

Test Plan:
- Write: START, 0x70, 0x40, 0x00, 0x0F, STOP.
  - ACK after each of the 4 bytes.
  - One reg_we with reg_addr=16'h4000, reg_wdata=8'h0F.
  - busy falls after STOP.
- Burst write: START, 0x70, 0x40, 0x15, 0xAA, 0x55, STOP.
  - reg_we at 16'h4015 = 8'hAA, then at 16'h4016 = 8'h55.
  - Repeat with C_AUTO_INC=0: both strobes at 16'h4015.
- Read: START, 0x71, 0x40, 0x00, then 2 data bytes with controller ACK then NACK. Model returns 8'hC3 then 8'h3C.
  - reg_re at 16'h4000 and 16'h4001.
  - sda carries C3 then 3C.
  - sda released after the NACK; next state S_IDLE.
- Address mismatch: START, 0x72, ...
  - sda never driven low.
  - No strobes; busy stays 0.
- Bus abort: STOP after 3 bits of the data byte → no reg_we, S_IDLE. Repeated START mid-address followed by a full valid write → the write completes normally.
- Wrap and reset: burst write starting at 16'hFFFF → second strobe at 16'h0000. Assert rst while the target is driving ACK → sda=z the next cycle, all outputs 0.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target for the codec control bus: START/STOP decode, 7-bit chip address match,
// 16-bit register pointer and byte-wide register access through a strobe interface.
module i2c_target #(
   parameter logic [6:0] C_CHIP_ADDRESS = 7'h38,
   parameter logic       C_AUTO_INC     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl,
   inout  wire         sda,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [7:0]  reg_rdata,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RX_CHIP_ADDRESS,
      S_TX_CHIP_ADDRESS_ACK,
      S_RX_ADDRESS,
      S_TX_ADDRESS_ACK,
      S_RX_SUB_ADDRESS,
      S_TX_SUB_ADDRESS_ACK,
      S_RX_WDATA,
      S_TX_WDATA_ACK,
      S_TX_RDATA,
      S_RX_RDATA_ACK
   } state_t;

   logic scl_meta, scl_sync, scl_prev;
   logic sda_meta, sda_sync, sda_prev;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t      state, state_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  rx_byte;
   logic        rnw, rnw_n;
   logic        sda_low, sda_low_n;
   logic        tx_pending, tx_pending_n;
   logic        re_d;
   logic [15:0] addr_n;
   logic [7:0]  wdata_n;
   logic        we_n, re_n, busy_n;

   // NOTE: synchronizer flops carry no reset so a reset never fabricates a bus edge.
   always_ff @(posedge clk) begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
   end

   assign scl_rise  = scl_sync & ~scl_prev;
   assign scl_fall  = ~scl_sync & scl_prev;
   assign start_det = scl_sync & sda_prev & ~sda_sync;
   assign stop_det  = scl_sync & ~sda_prev & sda_sync;
   assign rx_byte   = {shift[6:0], sda_sync};

   assign sda = sda_low ? 1'b0 : 1'bz;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shift_n      = shift;
      rnw_n        = rnw;
      sda_low_n    = sda_low;
      tx_pending_n = tx_pending;
      addr_n       = reg_addr;
      wdata_n      = reg_wdata;
      we_n         = 1'b0;
      re_n         = 1'b0;
      busy_n       = busy;

      // Read data arrives one cycle after the reg_re strobe.
      if (re_d) shift_n = reg_rdata;

      unique case (state)
         S_IDLE: ;

         S_RX_CHIP_ADDRESS, S_RX_ADDRESS, S_RX_SUB_ADDRESS, S_RX_WDATA: begin
            if (scl_rise) begin
               shift_n   = rx_byte;
               bit_cnt_n = bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  unique case (state)
                     S_RX_CHIP_ADDRESS: begin
                        rnw_n = rx_byte[0];
                        if (rx_byte[7:1] == C_CHIP_ADDRESS) begin
                           state_n = S_TX_CHIP_ADDRESS_ACK;
                           busy_n  = 1'b1;
                        end else begin
                           state_n = S_IDLE;
                        end
                     end
                     S_RX_ADDRESS: begin
                        addr_n[15:8] = rx_byte;
                        state_n      = S_TX_ADDRESS_ACK;
                     end
                     S_RX_SUB_ADDRESS: begin
                        addr_n[7:0] = rx_byte;
                        state_n     = S_TX_SUB_ADDRESS_ACK;
                     end
                     S_RX_WDATA: begin
                        wdata_n = rx_byte;
                        we_n    = 1'b1;
                        state_n = S_TX_WDATA_ACK;
                     end
                     default: ;
                  endcase
               end
            end
         end

         // sda_low doubles as the phase flag: low = waiting for the fall after bit 0.
         S_TX_CHIP_ADDRESS_ACK, S_TX_ADDRESS_ACK, S_TX_SUB_ADDRESS_ACK, S_TX_WDATA_ACK: begin
            if (scl_rise && sda_low && rnw && state == S_TX_SUB_ADDRESS_ACK) re_n = 1'b1;
            if (scl_fall) begin
               if (!sda_low) begin
                  sda_low_n = 1'b1;
               end else begin
                  sda_low_n = 1'b0;
                  bit_cnt_n = 3'd7;
                  unique case (state)
                     S_TX_CHIP_ADDRESS_ACK: state_n = S_RX_ADDRESS;
                     S_TX_ADDRESS_ACK:      state_n = S_RX_SUB_ADDRESS;
                     S_TX_SUB_ADDRESS_ACK: begin
                        if (rnw) begin
                           state_n   = S_TX_RDATA;
                           sda_low_n = ~shift[7];
                        end else begin
                           state_n = S_RX_WDATA;
                        end
                     end
                     S_TX_WDATA_ACK: begin
                        state_n = S_RX_WDATA;
                        if (C_AUTO_INC) addr_n = reg_addr + 16'd1;
                     end
                     default: ;
                  endcase
               end
            end
         end

         S_TX_RDATA: begin
            if (scl_fall) begin
               if (tx_pending) begin
                  tx_pending_n = 1'b0;
                  sda_low_n    = ~shift[7];
               end else if (bit_cnt == 3'd0) begin
                  sda_low_n = 1'b0;
                  state_n   = S_RX_RDATA_ACK;
               end else begin
                  shift_n   = {shift[6:0], 1'b0};
                  bit_cnt_n = bit_cnt - 3'd1;
                  sda_low_n = ~shift[6];
               end
            end
         end

         S_RX_RDATA_ACK: begin
            if (scl_rise) begin
               if (!sda_sync) begin
                  if (C_AUTO_INC) addr_n = reg_addr + 16'd1;
                  re_n         = 1'b1;
                  tx_pending_n = 1'b1;
                  bit_cnt_n    = 3'd7;
                  state_n      = S_TX_RDATA;
               end else begin
                  sda_low_n = 1'b0;
                  state_n   = S_IDLE;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase

      // Bus conditions override whatever the bit logic decided this cycle.
      if (start_det) begin
         state_n      = S_RX_CHIP_ADDRESS;
         bit_cnt_n    = 3'd7;
         sda_low_n    = 1'b0;
         tx_pending_n = 1'b0;
         busy_n       = 1'b0;
         we_n         = 1'b0;
         re_n         = 1'b0;
      end else if (stop_det) begin
         state_n      = S_IDLE;
         sda_low_n    = 1'b0;
         tx_pending_n = 1'b0;
         busy_n       = 1'b0;
         we_n         = 1'b0;
         re_n         = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= 3'd7;
         shift      <= '0;
         rnw        <= 1'b0;
         sda_low    <= 1'b0;
         tx_pending <= 1'b0;
         re_d       <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_we     <= 1'b0;
         reg_re     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift      <= shift_n;
         rnw        <= rnw_n;
         sda_low    <= sda_low_n;
         tx_pending <= tx_pending_n;
         re_d       <= reg_re;
         reg_addr   <= addr_n;
         reg_wdata  <= wdata_n;
         reg_we     <= we_n;
         reg_re     <= re_n;
         busy       <= busy_n;
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged controller drives the bus, expected register strobes
// are queued per target and a negedge monitor pops and compares them as they appear.
module tb_i2c_target;

   typedef struct packed {
      logic        is_we;
      logic [15:0] addr;
      logic [7:0]  data;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   logic scl;
   logic sda_c;
   wire  sda_bus;

   logic [15:0] reg_addr, reg_addr_ni;
   logic [7:0]  reg_wdata, reg_wdata_ni;
   logic        reg_we, reg_we_ni;
   logic        reg_re, reg_re_ni;
   logic [7:0]  reg_rdata;
   logic        busy, busy_ni;

   int checks = 0;
   int errors = 0;
   ev_t exp_q[$];
   ev_t exp_ni_q[$];
   logic watch = 1'b0;
   int drive_seen = 0;
   int busy_seen = 0;

   always #5 clk = ~clk;

   pullup (sda_bus);
   assign sda_bus = sda_c ? 1'b0 : 1'bz;

   i2c_target #(.C_CHIP_ADDRESS(7'h38), .C_AUTO_INC(1'b1)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   i2c_target #(.C_CHIP_ADDRESS(7'h3A), .C_AUTO_INC(1'b0)) dut_ni (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
      .reg_addr(reg_addr_ni), .reg_wdata(reg_wdata_ni), .reg_we(reg_we_ni), .reg_re(reg_re_ni),
      .reg_rdata(8'h00), .busy(busy_ni)
   );

   // Synchronous register store model: two known read locations.
   always @(posedge clk) begin
      if (reg_re)
         reg_rdata <= (reg_addr == 16'h4000) ? 8'hC3 : (reg_addr == 16'h4001) ? 8'h3C : 8'h00;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic expect_ev(input logic ni, input logic is_we, input logic [15:0] a,
                            input logic [7:0] d);
      ev_t e;
      e.is_we = is_we;
      e.addr  = a;
      e.data  = d;
      if (ni) exp_ni_q.push_back(e);
      else    exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      ev_t want;
      if (reg_we || reg_re) begin
         if (exp_q.size() == 0) begin
            check("main_unexpected_strobe", 32'({reg_we, reg_re}), 32'd0);
         end else begin
            want = exp_q.pop_front();
            check("main_strobe_kind", 32'(reg_we), 32'(want.is_we));
            check("main_strobe_addr", 32'(reg_addr), 32'(want.addr));
            if (want.is_we) check("main_wdata", 32'(reg_wdata), 32'(want.data));
         end
      end
      if (reg_we_ni || reg_re_ni) begin
         if (exp_ni_q.size() == 0) begin
            check("ni_unexpected_strobe", 32'({reg_we_ni, reg_re_ni}), 32'd0);
         end else begin
            want = exp_ni_q.pop_front();
            check("ni_strobe_kind", 32'(reg_we_ni), 32'(want.is_we));
            check("ni_strobe_addr", 32'(reg_addr_ni), 32'(want.addr));
            if (want.is_we) check("ni_wdata", 32'(reg_wdata_ni), 32'(want.data));
         end
      end
      if (watch && !sda_c && sda_bus === 1'b0) drive_seen++;
      if (watch && (busy || busy_ni)) busy_seen++;
   end

   // One scl period starting just after scl fell: 10 clk low, 10 clk high.
   task automatic clock_bit(input logic pull_low, output logic sampled);
      #30 sda_c = pull_low;
      #70 scl = 1'b1;
      #50 sampled = sda_bus;
      #50 scl = 1'b0;
   endtask

   task automatic start_cond();
      #30 sda_c = 1'b0;
      #70 scl = 1'b1;
      #100 sda_c = 1'b1;
      #100 scl = 1'b0;
   endtask

   task automatic stop_cond();
      #30 sda_c = 1'b1;
      #70 scl = 1'b1;
      #100 sda_c = 1'b0;
      #100;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
      clock_bit(1'b0, s);
      acked = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b0, s);
         d[i] = s;
      end
      clock_bit(~nack, s);
   endtask

   task automatic write_txn(input logic [7:0] chip, input logic [15:0] a,
                            input logic [7:0] d0, input logic [7:0] d1, input logic two,
                            input string tag);
      logic ack;
      start_cond();
      send_byte(chip, ack);  check({tag, "_ack_chip"}, 32'(ack), 32'd1);
      send_byte(a[15:8], ack); check({tag, "_ack_addr_hi"}, 32'(ack), 32'd1);
      send_byte(a[7:0], ack);  check({tag, "_ack_addr_lo"}, 32'(ack), 32'd1);
      send_byte(d0, ack);      check({tag, "_ack_d0"}, 32'(ack), 32'd1);
      if (two) begin
         send_byte(d1, ack);   check({tag, "_ack_d1"}, 32'(ack), 32'd1);
      end
      stop_cond();
   endtask

   initial begin
      logic       ack, s;
      logic [7:0] d;
      rst = 1'b1; scl = 1'b1; sda_c = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
      check("rst_strobes", 32'({reg_we, reg_re}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sda_released", 32'(sda_bus), 32'd1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single write with busy tracking.
      expect_ev(1'b0, 1'b1, 16'h4000, 8'h0F);
      start_cond();
      send_byte(8'h70, ack); check("wr_ack_chip", 32'(ack), 32'd1);
      check("wr_busy_after_match", 32'(busy), 32'd1);
      send_byte(8'h40, ack); check("wr_ack_addr_hi", 32'(ack), 32'd1);
      send_byte(8'h00, ack); check("wr_ack_addr_lo", 32'(ack), 32'd1);
      send_byte(8'h0F, ack); check("wr_ack_data", 32'(ack), 32'd1);
      stop_cond();
      check("wr_busy_after_stop", 32'(busy), 32'd0);

      // Burst write with auto-increment, then to the non-incrementing target.
      expect_ev(1'b0, 1'b1, 16'h4015, 8'hAA);
      expect_ev(1'b0, 1'b1, 16'h4016, 8'h55);
      write_txn(8'h70, 16'h4015, 8'hAA, 8'h55, 1'b1, "burst");
      expect_ev(1'b1, 1'b1, 16'h4015, 8'hAA);
      expect_ev(1'b1, 1'b1, 16'h4015, 8'h55);
      write_txn(8'h74, 16'h4015, 8'hAA, 8'h55, 1'b1, "burst_ni");

      // Read two bytes: controller ACKs the first, NACKs the second.
      expect_ev(1'b0, 1'b0, 16'h4000, 8'h00);
      expect_ev(1'b0, 1'b0, 16'h4001, 8'h00);
      start_cond();
      send_byte(8'h71, ack); check("rd_ack_chip", 32'(ack), 32'd1);
      send_byte(8'h40, ack); check("rd_ack_addr_hi", 32'(ack), 32'd1);
      send_byte(8'h00, ack); check("rd_ack_addr_lo", 32'(ack), 32'd1);
      read_byte(1'b0, d); check("rd_byte0", 32'(d), 32'hC3);
      read_byte(1'b1, d); check("rd_byte1", 32'(d), 32'h3C);
      #60 check("rd_sda_released", 32'(sda_bus), 32'd1);
      clock_bit(1'b0, s); check("rd_idle_after_nack", 32'(s), 32'd1);
      stop_cond();

      // Address mismatch: never drives, never busy.
      drive_seen = 0; busy_seen = 0; watch = 1'b1;
      start_cond();
      send_byte(8'h72, ack); check("mm_nack", 32'(ack), 32'd0);
      send_byte(8'h40, ack); check("mm_nack_next", 32'(ack), 32'd0);
      stop_cond();
      watch = 1'b0;
      check("mm_no_drive", 32'(drive_seen), 32'd0);
      check("mm_no_busy", 32'(busy_seen), 32'd0);

      // STOP three bits into a data byte: no write.
      start_cond();
      send_byte(8'h70, ack); send_byte(8'h40, ack); send_byte(8'h00, ack);
      clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s);
      stop_cond();
      check("abort_busy", 32'(busy), 32'd0);

      // Repeated START mid-address, then a complete write.
      expect_ev(1'b0, 1'b1, 16'h1234, 8'h99);
      start_cond();
      send_byte(8'h70, ack);
      clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
      write_txn(8'h70, 16'h1234, 8'h99, 8'h00, 1'b0, "rstart");

      // Pointer wrap.
      expect_ev(1'b0, 1'b1, 16'hFFFF, 8'h11);
      expect_ev(1'b0, 1'b1, 16'h0000, 8'h22);
      write_txn(8'h70, 16'hFFFF, 8'h11, 8'h22, 1'b1, "wrap");

      // Reset while the target drives the chip-address ACK.
      start_cond();
      for (int i = 7; i >= 0; i--) begin
         d = 8'h70;
         clock_bit(~d[i], s);
      end
      #30 sda_c = 1'b0;
      #50 check("rst_ack_driven", 32'(sda_bus), 32'd0);
      check("rst_busy_before", 32'(busy), 32'd1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("rst_mid_sda", 32'(sda_bus), 32'd1);
      check("rst_mid_reg_addr", 32'(reg_addr), 32'd0);
      check("rst_mid_reg_wdata", 32'(reg_wdata), 32'd0);
      check("rst_mid_strobes", 32'({reg_we, reg_re}), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #50 scl = 1'b1;
      #100 scl = 1'b0;
      clock_bit(1'b0, s); check("rst_stays_released", 32'(s), 32'd1);
      clock_bit(1'b1, s);
      stop_cond();

      repeat (20) @(negedge clk);
      check("sb_main_drained", 32'(exp_q.size()), 32'd0);
      check("sb_ni_drained", 32'(exp_ni_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
